sync_delay_line: RTL and testbench

//  Runtime-programmable delay line for the video timing bundle (vs/hs/de) plus an optional

---
 rtl/sync_delay_line.sv | 159 +++++++++++++++
 tb/tb_sync_delay_line.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_delay_line.sv
// Programmable delay line for vs/hs/de plus pixel data, built on a circular buffer.
// Outputs stay blanked while the buffer refills after reset or after a delay change.
module sync_delay_line #(
  parameter int   MAX_DELAY     = 64,
  parameter int   DEFAULT_DELAY = 7,
  parameter int   DATA_W        = 24,
  parameter logic SYNC_IDLE     = 1'b0,
  parameter bit   APPLY_AT_VS   = 1'b0,
  localparam int  DW            = $clog2(MAX_DELAY + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vs_in,
  input  logic              hs_in,
  input  logic              de_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DW-1:0]     delay_sel,
  input  logic              delay_load,
  output logic              vs_out,
  output logic              hs_out,
  output logic              de_out,
  output logic [DATA_W-1:0] data_out,
  output logic              primed,
  output logic              pending,
  output logic [DW-1:0]     delay_act
);

  localparam int AW = $clog2(MAX_DELAY);
  localparam int WW = DATA_W + 3;
  localparam logic [WW-1:0] BLANK = {SYNC_IDLE, SYNC_IDLE, 1'b0, {DATA_W{1'b0}}};

  typedef enum logic {PRIME, RUN} state_t;

  state_t          state_reg, state_next;
  logic [DW-1:0]   delay_reg, delay_next;
  logic [DW-1:0]   fill_reg, fill_next;
  logic [DW-1:0]   pend_val_reg, pend_val_next;
  logic            pend_reg, pend_next;
  logic            primed_reg, primed_next;
  logic            vs_prev_reg;
  logic [AW-1:0]   wr_ptr_reg;
  logic [WW-1:0]   out_word_reg, out_word_next;

  logic [WW-1:0]   mem [MAX_DELAY];
  logic [WW-1:0]   in_word, tap_word;
  logic [AW:0]     tap_sum;
  logic [AW-1:0]   rd_addr;
  logic [DW-1:0]   sel_clamped, new_d;
  logic            vs_act, apply;

  function automatic logic [DW-1:0] clamp_delay(input logic [DW-1:0] v);
    if (v == '0)
      return DW'(1);
    else if (int'(v) > MAX_DELAY)
      return DW'(MAX_DELAY);
    else
      return v;
  endfunction

  assign in_word = {vs_in, hs_in, de_in, data_in};

  // Tap sits D-1 entries behind the write pointer; D=1 bypasses the buffer.
  always_comb begin
    tap_sum = {1'b0, wr_ptr_reg} + (AW+1)'(MAX_DELAY) - (AW+1)'(delay_reg - DW'(1));
    if (tap_sum >= (AW+1)'(MAX_DELAY))
      rd_addr = AW'(tap_sum - (AW+1)'(MAX_DELAY));
    else
      rd_addr = AW'(tap_sum);
    tap_word = (delay_reg == DW'(1)) ? in_word : mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    mem[wr_ptr_reg] <= in_word;
  end

  always_comb begin
    vs_act      = (vs_in != SYNC_IDLE) && (vs_prev_reg == SYNC_IDLE);
    sel_clamped = clamp_delay(delay_sel);
    apply       = 1'b0;
    new_d       = sel_clamped;
    if (APPLY_AT_VS) begin
      apply = vs_act && (delay_load || pend_reg);
      new_d = delay_load ? sel_clamped : pend_val_reg;
    end else begin
      apply = delay_load;
    end
  end

  always_comb begin
    state_next    = state_reg;
    delay_next    = delay_reg;
    fill_next     = fill_reg;
    pend_next     = pend_reg;
    pend_val_next = pend_val_reg;
    out_word_next = BLANK;
    primed_next   = 1'b0;
    if (apply) begin
      delay_next = new_d;
      state_next = PRIME;
      fill_next  = '0;
      pend_next  = 1'b0;
    end else begin
      if (APPLY_AT_VS && delay_load) begin
        pend_next     = 1'b1;
        pend_val_next = sel_clamped;
      end
      case (state_reg)
        PRIME: begin
          // This cycle's write completes the fill when D samples are in.
          if (fill_reg + DW'(1) >= delay_reg) begin
            state_next    = RUN;
            out_word_next = tap_word;
            primed_next   = 1'b1;
          end else begin
            fill_next = fill_reg + DW'(1);
          end
        end
        RUN: begin
          out_word_next = tap_word;
          primed_next   = 1'b1;
        end
        default: state_next = PRIME;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= PRIME;
      delay_reg    <= DW'(DEFAULT_DELAY);
      fill_reg     <= '0;
      pend_reg     <= 1'b0;
      pend_val_reg <= DW'(DEFAULT_DELAY);
      primed_reg   <= 1'b0;
      vs_prev_reg  <= SYNC_IDLE;
      wr_ptr_reg   <= '0;
      out_word_reg <= BLANK;
    end else begin
      state_reg    <= state_next;
      delay_reg    <= delay_next;
      fill_reg     <= fill_next;
      pend_reg     <= pend_next;
      pend_val_reg <= pend_val_next;
      primed_reg   <= primed_next;
      vs_prev_reg  <= vs_in;
      wr_ptr_reg   <= (wr_ptr_reg == AW'(MAX_DELAY - 1)) ? '0 : wr_ptr_reg + AW'(1);
      out_word_reg <= out_word_next;
    end
  end

  assign vs_out    = out_word_reg[WW-1];
  assign hs_out    = out_word_reg[WW-2];
  assign de_out    = out_word_reg[WW-3];
  assign data_out  = out_word_reg[DATA_W-1:0];
  assign primed    = primed_reg;
  assign pending   = pend_reg;
  assign delay_act = delay_reg;

endmodule

// File: tb/tb_sync_delay_line.sv
// Bench for sync_delay_line: two instances (immediate and vs-synchronised loading)
// checked every cycle against a cycle-indexed input history model.
module tb_sync_delay_line;

  localparam int DEF = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vs_in = 1'b0, hs_in = 1'b0, de_in = 1'b0;
  logic [23:0] data_in = '0;
  logic [6:0]  sel_a = '0, sel_b = '0;
  logic        ld_a = 1'b0, ld_b = 1'b0;

  logic        vs_a, hs_a, de_a, primed_a, pending_a;
  logic [23:0] data_a;
  logic [6:0]  dact_a;
  logic        vs_b, hs_b, de_b, primed_b, pending_b;
  logic [23:0] data_b;
  logic [6:0]  dact_b;

  logic        rst_s = 1'b1, vs_s = 1'b0, hs_s = 1'b0, de_s = 1'b0;
  logic [23:0] data_s = '0;
  logic        ld_a_s = 1'b0, ld_b_s = 1'b0;
  logic [6:0]  sel_a_s = '0, sel_b_s = '0;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [26:0] hist [0:4095];
  int          m_d [2];
  int          m_e [2];
  int          m_pv [2];
  bit          m_pend [2];
  logic        m_vsp;

  always #5 clk = ~clk;

  sync_delay_line #(.APPLY_AT_VS(1'b0)) dut_a (
    .clk(clk), .reset(rst), .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in),
    .data_in(data_in), .delay_sel(sel_a), .delay_load(ld_a),
    .vs_out(vs_a), .hs_out(hs_a), .de_out(de_a), .data_out(data_a),
    .primed(primed_a), .pending(pending_a), .delay_act(dact_a)
  );

  sync_delay_line #(.APPLY_AT_VS(1'b1)) dut_b (
    .clk(clk), .reset(rst), .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in),
    .data_in(data_in), .delay_sel(sel_b), .delay_load(ld_b),
    .vs_out(vs_b), .hs_out(hs_b), .de_out(de_b), .data_out(data_b),
    .primed(primed_b), .pending(pending_b), .delay_act(dact_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic int clampd(input int v);
    if (v == 0) return 1;
    if (v > 64) return 64;
    return v;
  endfunction

  // Expected output at cycle cyc: input from D cycles back once D samples exist since entry.
  task automatic model_check(input int k, input logic [35:0] got);
    logic [26:0] w;
    bit          pr;
    pr = (cyc >= m_e[k] + m_d[k]);
    w  = pr ? hist[cyc - m_d[k]] : 27'd0;
    check((k == 0) ? "dut_a" : "dut_b", {28'd0, got}, {28'd0, m_pend[k], pr, 7'(m_d[k]), w});
  endtask

  task automatic step();
    bit act;
    @(posedge clk);
    #1;
    rst = rst_s; vs_in = vs_s; hs_in = hs_s; de_in = de_s; data_in = data_s;
    ld_a = ld_a_s; sel_a = sel_a_s; ld_b = ld_b_s; sel_b = sel_b_s;
    @(negedge clk);
    if (rst_s) begin
      for (int k = 0; k < 2; k++) begin
        m_d[k] = DEF; m_e[k] = cyc + 1; m_pend[k] = 1'b0;
      end
      m_vsp = 1'b0;
    end
    model_check(0, {pending_a, primed_a, dact_a, vs_a, hs_a, de_a, data_a});
    model_check(1, {pending_b, primed_b, dact_b, vs_b, hs_b, de_b, data_b});
    if (!rst_s) begin
      hist[cyc] = {vs_s, hs_s, de_s, data_s};
      act = vs_s && !m_vsp;
      if (ld_a_s) begin
        m_d[0] = clampd(int'(sel_a_s)); m_e[0] = cyc + 1;
      end
      if (act && ld_b_s) begin
        m_d[1] = clampd(int'(sel_b_s)); m_e[1] = cyc + 1; m_pend[1] = 1'b0;
      end else if (act && m_pend[1]) begin
        m_d[1] = m_pv[1]; m_e[1] = cyc + 1; m_pend[1] = 1'b0;
      end else if (ld_b_s) begin
        m_pend[1] = 1'b1; m_pv[1] = clampd(int'(sel_b_s));
      end
      m_vsp = vs_s;
    end
    cyc++;
    ld_a_s = 1'b0;
    ld_b_s = 1'b0;
  endtask

  task automatic rnd_inputs();
    if ($urandom_range(0, 19) == 0) vs_s = ~vs_s;
    hs_s   = 1'($urandom);
    de_s   = 1'($urandom);
    data_s = 24'($urandom);
  endtask

  task automatic run_after_load(input int n);
    for (int i = 0; i < n; i++) begin
      if (i < 20) begin
        hs_s = 1'b0; de_s = (i == 3); data_s = (i == 3) ? 24'hA5A5A5 : 24'h0;
      end else begin
        rnd_inputs();
      end
      step();
    end
  endtask

  task automatic load_a(input logic [6:0] v);
    $display("txn load_a sel=%0d cyc=%0d", v, cyc);
    ld_a_s = 1'b1; sel_a_s = v;
  endtask

  initial begin
    int          n;
    logic [23:0] rec;

    // Power-on reset, then a ramp to see the first valid sample land at cycle 7.
    repeat (3) step();
    check("rst_de", de_a, 0);
    check("rst_primed", primed_a, 0);
    check("rst_dact", dact_a, DEF);
    rst_s = 1'b0;
    $display("txn reset_release cyc=%0d", cyc);
    for (int i = 0; i < 40; i++) begin
      de_s = 1'b1; data_s = 24'(i + 1);
      step();
      if (i == 6) check("prime_blank", primed_a, 0);
      if (i == 7) begin
        check("first_data", data_a, 1);
        check("first_primed", primed_a, 1);
      end
    end

    // vs-synchronised load: 5 then 9 mid-frame, applied at the vs activation.
    $display("txn b_loads_5_9 cyc=%0d", cyc);
    for (int i = 0; i < 60; i++) begin
      rnd_inputs();
      vs_s = 1'b0;
      if (i == 10) begin ld_b_s = 1'b1; sel_b_s = 7'd5; end
      if (i == 20) begin ld_b_s = 1'b1; sel_b_s = 7'd9; end
      step();
      if (i == 30) begin
        check("b_pending", pending_b, 1);
        check("b_old_d", dact_b, DEF);
      end
    end
    vs_s = 1'b1;
    $display("txn b_vs_activation cyc=%0d", cyc);
    step();
    check("b_at_m_d", dact_b, DEF);
    check("b_at_m_pend", pending_b, 1);
    step();
    check("b_after_m_d", dact_b, 9);
    check("b_after_m_pend", pending_b, 0);

    // Extreme delays across many pointer wraps.
    load_a(7'd1);
    run_after_load(250);
    load_a(7'd64);
    run_after_load(250);

    // Clamping of out-of-range requests.
    load_a(7'd0);
    step();
    step();
    check("clamp_lo", dact_a, 1);
    load_a(7'd100);
    step();
    step();
    check("clamp_hi", dact_a, 64);
    for (int i = 0; i < 80; i++) begin rnd_inputs(); step(); end

    // Reload to 12 while running.
    load_a(7'd12);
    rnd_inputs();
    step();
    rec = '0;
    for (int j = 1; j <= 13; j++) begin
      rnd_inputs();
      if (j == 1) rec = data_s;
      step();
      if (j == 12) check("reload_blank", primed_a, 0);
      if (j == 13) begin
        check("reload_data", data_a, rec);
        check("reload_primed", primed_a, 1);
      end
    end

    // Random loads on both instances with random vs activity.
    $display("txn random_phase cyc=%0d", cyc);
    for (int i = 0; i < 1200; i++) begin
      rnd_inputs();
      if ($urandom_range(0, 49) == 0) begin ld_a_s = 1'b1; sel_a_s = 7'($urandom); end
      if ($urandom_range(0, 49) == 0) begin ld_b_s = 1'b1; sel_b_s = 7'($urandom); end
      step();
    end

    // Reset mid-run for 3 cycles, then priming repeats with the default delay.
    $display("txn midrun_reset cyc=%0d", cyc);
    rst_s = 1'b1;
    repeat (3) step();
    check("mid_rst_de", de_a, 0);
    check("mid_rst_dact", dact_a, DEF);
    check("mid_rst_pend", pending_b, 0);
    rst_s = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      de_s = 1'b1; data_s = 24'(i + 100); vs_s = 1'b0;
      step();
      if (i == 6) check("re_prime_blank", primed_a, 0);
      if (i == 7) begin
        check("re_first_data", data_a, 100);
        n++;
      end
    end
    check("re_first_seen", 64'(n), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
